regfile_reader: RTL and testbench
=================================

# regfile_reader

Read side of the 32×32 processor register file. It takes the register array exported by the register-file write block and provides two synchronous read ports for the datapath. It also includes a handshaked dump engine that streams a range of registers, one per transfer, to a debug sink such as a display or UART front end. An optional write-bypass path lets a read issued in the same cycle as a write return the new value.

## Interface
Parameters:
- DUMP_FIRST, default 0: first register index streamed by the dump engine.
- DUMP_LAST, default 31: last register index streamed. DUMP_FIRST ≤ DUMP_LAST ≤ 31 is required.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- regs  in  32×32 (unpacked [31:0] of [31:0])  current register-file contents.
- we3  in  1  write enable of the register-file write port (snooped).
- wa3  in  5  write address of the write port (snooped).
- wd3  in  32  write data of the write port (snooped).
- ra1, ra2  in  5 each  read addresses.
- rd1, rd2  out  32 each  registered read data.
- dump_start  in  1  single-cycle request to start a dump.
- dump_busy  out  1  high from acceptance of dump_start until the cycle after dump_done.
- dump_valid  out  1  dump_addr/dump_data hold a pending element.
- dump_ready  in  1  sink accepts the element.
- dump_addr  out  5  index of the pending element.
- dump_data  out  32  value of the pending element.
- dump_done  out  1  one-cycle pulse after the last element is accepted.

## Operation
- Read ports: on each edge, rd1 <= value(ra1) and rd2 <= value(ra2).
- value(0) is always 32'h0, regardless of regs[0] or snooped writes.
- value(n), n≠0: regs[n], subject to bypass (see Configuration).
- Dump FSM states: IDLE, SEND, DONE.
  - IDLE: dump_valid=0, dump_busy=0. If dump_start=1: load idx=DUMP_FIRST, snapshot dump_data<=value(DUMP_FIRST), dump_addr<=DUMP_FIRST, go to SEND.
  - SEND: dump_valid=1, dump_busy=1. Transfer occurs when dump_valid && dump_ready.
    - On transfer with idx<DUMP_LAST: idx+1, snapshot value(idx+1), stay in SEND.
    - On transfer with idx==DUMP_LAST: go to DONE.
    - Without a transfer, dump_addr and dump_data hold stable, even if regs changes.
  - DONE: dump_valid=0, dump_done=1 for exactly one cycle, dump_busy=1; next state IDLE.
- dump_start is ignored in SEND and DONE, with no queuing.
- The dump and read ports are independent; both may be active in the same cycle.

## Timing
- Read latency is 1 cycle: an address presented before edge N appears on rd1/rd2 after edge N.
- The first dump element is valid the cycle after dump_start is sampled.
- Back-to-back transfers are possible: with dump_ready held high, one element per cycle. A full 0..31 dump takes 32 SEND cycles plus 1 DONE cycle.
- Reset (rst=0), asynchronous and immediate:
  - rd1, rd2, dump_data = 0; dump_addr = 0.
  - dump_valid, dump_busy, dump_done = 0; FSM in IDLE.
- Reset mid-dump abandons the dump; no dump_done is produced. A new dump_start is required after reset is released.
- A dump_start in the same cycle as the last transfer is ignored, because the FSM is not yet in IDLE.

## Configuration
- REGREAD_BYPASS_EN defined: if we3=1 and wa3==addr and addr≠0 in the sampling cycle, value(addr)=wd3. This applies to both read ports and to dump snapshots, and gives the datapath write-before-read semantics.
- Not defined: value(addr)=regs[addr] as seen in the sampling cycle, so a same-cycle write is returned one cycle later. No other behaviour changes.

## Test plan
- Reset, then regs[5]=32'hDEADBEEF; ra1=5, ra2=0 -> after 1 edge, rd1=32'hDEADBEEF and rd2=0. With regs[0] forced to 32'h1, rd2 still reads 0.
- Same-cycle write: regs[7]=32'h11, we3=1, wa3=7, wd3=32'h22, ra1=7 -> rd1=32'h22 with REGREAD_BYPASS_EN and 32'h11 without. With wa3=0 and ra1=0, rd1=0 in both builds.
- Full dump with regs[n]=n*32'h101 and dump_ready tied high -> 32 transfers with dump_addr 0..31 and matching data, then dump_done for one cycle, then dump_busy low.
- Backpressure: toggle dump_ready every other cycle and change regs[3] while element 3 is pending -> dump_data holds the snapshot value until accepted, and no element is skipped or duplicated.
- Reset mid-dump at element 10 -> dump_valid and dump_busy drop immediately, no dump_done pulse; a new dump_start restarts at DUMP_FIRST.
- Parameter DUMP_FIRST=4, DUMP_LAST=6, plus dump_start asserted during SEND -> exactly 3 elements (4, 5, 6) and the extra start is ignored.

Source files
------------

// File: rtl/regfile_reader.sv
// -----------------------------------------------------------------------------
// regfile_reader
//   Read side of the 32x32 register file: two registered read ports plus a
//   handshaked dump engine that streams registers DUMP_FIRST..DUMP_LAST to a
//   debug sink, one element per valid/ready transfer.
//
//   Optional feature macro: REGREAD_BYPASS_EN
//     defined   -> a write snooped on we3/wa3/wd3 in the sampling cycle is
//                  forwarded to read ports and dump snapshots.
//     undefined -> reads return regs[] as seen in the sampling cycle.
//
// Parameters:
//   DUMP_FIRST  first register index streamed (default 0)
//   DUMP_LAST   last register index streamed  (default 31)
//
// Ports:
//   clk         system clock, rising edge
//   rst         asynchronous active-low reset
//   regs        current register-file contents [31:0] x 32
//   we3/wa3/wd3 snooped write port of the register file
//   ra1/ra2     read addresses
//   rd1/rd2     registered read data (1-cycle latency)
//   dump_start  single-cycle dump request (ignored while a dump is active)
//   dump_busy   dump in progress (SEND or DONE)
//   dump_valid  dump_addr/dump_data hold a pending element
//   dump_ready  sink accepts the pending element
//   dump_addr   index of pending element
//   dump_data   snapshot value of pending element
//   dump_done   one-cycle pulse after the last element is accepted
// -----------------------------------------------------------------------------
module regfile_reader #(
    parameter int unsigned DUMP_FIRST = 0,
    parameter int unsigned DUMP_LAST  = 31
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] regs [31:0],
    input  logic        we3,
    input  logic [4:0]  wa3,
    input  logic [31:0] wd3,
    input  logic [4:0]  ra1,
    input  logic [4:0]  ra2,
    output logic [31:0] rd1,
    output logic [31:0] rd2,
    input  logic        dump_start,
    output logic        dump_busy,
    output logic        dump_valid,
    input  logic        dump_ready,
    output logic [4:0]  dump_addr,
    output logic [31:0] dump_data,
    output logic        dump_done
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEND,
        ST_DONE
    } state_t;

    localparam logic [4:0] FIRST_IDX = 5'(DUMP_FIRST);
    localparam logic [4:0] LAST_IDX  = 5'(DUMP_LAST);

    state_t      state_q, state_d;
    logic [31:0] rd1_q, rd1_d;
    logic [31:0] rd2_q, rd2_d;
    logic [4:0]  dump_addr_q, dump_addr_d;
    logic [31:0] dump_data_q, dump_data_d;

`ifndef REGREAD_BYPASS_EN
    // Snooped write port only matters when forwarding is built in.
    logic unused_snoop;
    assign unused_snoop = ^{we3, wa3, wd3};
`endif

    // Architectural read value: register 0 is hard-wired to zero.
    function automatic logic [31:0] value_of(input logic [4:0] a);
        logic [31:0] v;
        if (a == '0) begin
            v = '0;
        end else begin
            v = regs[a];
`ifdef REGREAD_BYPASS_EN
            if (we3 && (wa3 == a)) begin
                v = wd3;
            end
`endif
        end
        return v;
    endfunction

    always_comb begin
        state_d     = state_q;
        dump_addr_d = dump_addr_q;
        dump_data_d = dump_data_q;
        dump_valid  = 1'b0;
        dump_busy   = 1'b0;
        dump_done   = 1'b0;
        rd1_d       = value_of(ra1);
        rd2_d       = value_of(ra2);

        case (state_q)
            ST_IDLE: begin
                if (dump_start) begin
                    dump_addr_d = FIRST_IDX;
                    dump_data_d = value_of(FIRST_IDX);
                    state_d     = ST_SEND;
                end
            end
            ST_SEND: begin
                dump_valid = 1'b1;
                dump_busy  = 1'b1;
                // Without a transfer the snapshot is held, even if regs moves.
                if (dump_ready) begin
                    if (dump_addr_q == LAST_IDX) begin
                        state_d = ST_DONE;
                    end else begin
                        dump_addr_d = dump_addr_q + 5'd1;
                        dump_data_d = value_of(dump_addr_q + 5'd1);
                    end
                end
            end
            ST_DONE: begin
                dump_busy = 1'b1;
                dump_done = 1'b1;
                state_d   = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            rd1_q       <= '0;
            rd2_q       <= '0;
            dump_addr_q <= '0;
            dump_data_q <= '0;
        end else begin
            state_q     <= state_d;
            rd1_q       <= rd1_d;
            rd2_q       <= rd2_d;
            dump_addr_q <= dump_addr_d;
            dump_data_q <= dump_data_d;
        end
    end

    assign rd1       = rd1_q;
    assign rd2       = rd2_q;
    assign dump_addr = dump_addr_q;
    assign dump_data = dump_data_q;

endmodule

// File: tb/tb_regfile_reader.sv
// -----------------------------------------------------------------------------
// tb_regfile_reader
//   Directed self-checking bench for regfile_reader. A default-parameter
//   instance covers the read ports and the full-range dump; a second instance
//   with DUMP_FIRST=4, DUMP_LAST=6 covers the narrowed range.
// -----------------------------------------------------------------------------
module tb_regfile_reader;

    logic        clk;
    logic        rst;
    logic [31:0] regs [31:0];
    logic        we3;
    logic [4:0]  wa3;
    logic [31:0] wd3;
    logic [4:0]  ra1, ra2;
    logic [31:0] rd1, rd2;
    logic        dump_start, dump_busy, dump_valid, dump_ready, dump_done;
    logic [4:0]  dump_addr;
    logic [31:0] dump_data;

    logic [31:0] rd1_b, rd2_b;
    logic        start_b, busy_b, valid_b, ready_b, done_b;
    logic [4:0]  addr_b;
    logic [31:0] data_b;

    int unsigned tests;
    int unsigned failed;

    regfile_reader u_dut (
        .clk        (clk),
        .rst        (rst),
        .regs       (regs),
        .we3        (we3),
        .wa3        (wa3),
        .wd3        (wd3),
        .ra1        (ra1),
        .ra2        (ra2),
        .rd1        (rd1),
        .rd2        (rd2),
        .dump_start (dump_start),
        .dump_busy  (dump_busy),
        .dump_valid (dump_valid),
        .dump_ready (dump_ready),
        .dump_addr  (dump_addr),
        .dump_data  (dump_data),
        .dump_done  (dump_done)
    );

    regfile_reader #(
        .DUMP_FIRST (4),
        .DUMP_LAST  (6)
    ) u_dut_range (
        .clk        (clk),
        .rst        (rst),
        .regs       (regs),
        .we3        (we3),
        .wa3        (wa3),
        .wd3        (wd3),
        .ra1        (ra1),
        .ra2        (ra2),
        .rd1        (rd1_b),
        .rd2        (rd2_b),
        .dump_start (start_b),
        .dump_busy  (busy_b),
        .dump_valid (valid_b),
        .dump_ready (ready_b),
        .dump_addr  (addr_b),
        .dump_data  (data_b),
        .dump_done  (done_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] pattern(input int unsigned n);
        return 32'(n) * 32'h101;
    endfunction

    initial begin
        int unsigned exp_idx;
        int unsigned cyc;
        logic        changed;

        tests      = 0;
        failed     = 0;
        rst        = 1'b0;
        we3        = 1'b0;
        wa3        = '0;
        wd3        = '0;
        ra1        = '0;
        ra2        = '0;
        dump_start = 1'b0;
        dump_ready = 1'b0;
        start_b    = 1'b0;
        ready_b    = 1'b0;
        for (int i = 0; i < 32; i++) regs[i] = pattern(i);
        regs[5] = 32'hDEADBEEF;

        // Reset state
        step();
        step();
        check("rst_rd1", rd1, 32'h0);
        check("rst_rd2", rd2, 32'h0);
        check("rst_valid", {31'b0, dump_valid}, 32'h0);
        check("rst_busy", {31'b0, dump_busy}, 32'h0);
        check("rst_done", {31'b0, dump_done}, 32'h0);
        check("rst_addr", {27'b0, dump_addr}, 32'h0);
        check("rst_data", dump_data, 32'h0);
        rst = 1'b1;

        // Read ports, register 0 hard-wired
        ra1 = 5'd5;
        ra2 = 5'd0;
        step();
        check("rd1_r5", rd1, 32'hDEADBEEF);
        check("rd2_r0", rd2, 32'h0);
        regs[0] = 32'h1;
        ra1 = 5'd31;
        step();
        check("rd2_r0_forced", rd2, 32'h0);
        check("rd1_r31", rd1, pattern(31));

        // Same-cycle write
        regs[7] = 32'h11;
        we3 = 1'b1;
        wa3 = 5'd7;
        wd3 = 32'h22;
        ra1 = 5'd7;
        ra2 = 5'd6;
        step();
`ifdef REGREAD_BYPASS_EN
        check("bypass_rd1", rd1, 32'h22);
`else
        check("bypass_rd1", rd1, 32'h11);
`endif
        check("bypass_other", rd2, pattern(6));
        wa3 = 5'd0;
        wd3 = 32'h33;
        ra1 = 5'd0;
        step();
        check("bypass_r0", rd1, 32'h0);
        we3 = 1'b0;
        regs[0] = 32'h0;
        regs[5] = pattern(5);
        regs[7] = pattern(7);

        // Full dump, sink always ready
        dump_ready = 1'b1;
        dump_start = 1'b1;
        step();
        dump_start = 1'b0;
        for (int i = 0; i < 32; i++) begin
            check("full_valid", {31'b0, dump_valid}, 32'h1);
            check("full_addr", {27'b0, dump_addr}, 32'(i));
            check("full_data", dump_data, pattern(i));
            check("full_nodone", {31'b0, dump_done}, 32'h0);
            step();
        end
        check("full_done", {31'b0, dump_done}, 32'h1);
        check("full_done_busy", {31'b0, dump_busy}, 32'h1);
        check("full_done_valid", {31'b0, dump_valid}, 32'h0);
        step();
        check("full_idle_busy", {31'b0, dump_busy}, 32'h0);
        check("full_idle_done", {31'b0, dump_done}, 32'h0);

        // Backpressure with regs[3] changing while element 3 is pending
        dump_ready = 1'b0;
        dump_start = 1'b1;
        step();
        dump_start = 1'b0;
        exp_idx = 0;
        cyc = 0;
        changed = 1'b0;
        while (exp_idx < 32 && cyc < 100) begin
            check("bp_valid", {31'b0, dump_valid}, 32'h1);
            check("bp_addr", {27'b0, dump_addr}, 32'(exp_idx));
            check("bp_data", dump_data, pattern(exp_idx));
            dump_ready = cyc[0];
            if (exp_idx == 3 && !changed) begin
                regs[3] = 32'hCAFEF00D;
                changed = 1'b1;
            end
            step();
            if (dump_ready) exp_idx++;
            cyc++;
        end
        check("bp_count", exp_idx, 32'd32);
        check("bp_done", {31'b0, dump_done}, 32'h1);
        dump_ready = 1'b0;
        regs[3] = pattern(3);
        step();

        // Reset mid-dump at element 10
        dump_ready = 1'b1;
        dump_start = 1'b1;
        step();
        dump_start = 1'b0;
        for (int i = 0; i < 10; i++) step();
        check("mid_addr10", {27'b0, dump_addr}, 32'd10);
        #2;
        rst = 1'b0;
        #1;
        check("mid_rst_valid", {31'b0, dump_valid}, 32'h0);
        check("mid_rst_busy", {31'b0, dump_busy}, 32'h0);
        check("mid_rst_addr", {27'b0, dump_addr}, 32'h0);
        check("mid_rst_data", dump_data, 32'h0);
        step();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("mid_no_done", {31'b0, dump_done}, 32'h0);
            check("mid_no_busy", {31'b0, dump_busy}, 32'h0);
        end
        dump_start = 1'b1;
        step();
        dump_start = 1'b0;
        check("restart_addr", {27'b0, dump_addr}, 32'd0);
        check("restart_valid", {31'b0, dump_valid}, 32'h1);
        dump_ready = 1'b0;
        rst = 1'b0;
        step();
        rst = 1'b1;
        step();

        // Narrowed range instance: 4..6, second start during SEND ignored
        ready_b = 1'b1;
        start_b = 1'b1;
        step();
        start_b = 1'b0;
        check("rng_addr4", {27'b0, addr_b}, 32'd4);
        check("rng_data4", data_b, pattern(4));
        start_b = 1'b1;
        step();
        start_b = 1'b0;
        check("rng_addr5", {27'b0, addr_b}, 32'd5);
        check("rng_data5", data_b, pattern(5));
        step();
        check("rng_addr6", {27'b0, addr_b}, 32'd6);
        check("rng_data6", data_b, pattern(6));
        check("rng_valid6", {31'b0, valid_b}, 32'h1);
        step();
        check("rng_done", {31'b0, done_b}, 32'h1);
        check("rng_done_valid", {31'b0, valid_b}, 32'h0);
        step();
        check("rng_idle_busy", {31'b0, busy_b}, 32'h0);
        check("rng_idle_done", {31'b0, done_b}, 32'h0);
        step();
        check("rng_no_restart", {31'b0, valid_b}, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
